// File: rtl/trap_sequencer_pkg.sv
// Shared constants and FSM state type for the trap entry/return sequencer.
// Holds CSR addresses, mstatus field positions, exception and privilege codes.
package trap_sequencer_pkg;

  localparam logic [1:0] XLEN_32B = 2'd1;
  localparam logic [1:0] XLEN_64B = 2'd2;

  // Exception codes follow the mcause numbering; NO_E marks an empty slot.
  localparam logic [3:0] NO_E                    = 4'hF;
  localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] E_FETCH_ACCESS_FAULT    = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
  localparam logic [3:0] E_BREAKPOINT            = 4'd3;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
  localparam logic [3:0] E_ECALL                 = 4'd8;

  localparam logic [3:0] ECALL_CAUSE_BASE = 4'd8;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] USER       = 2'b00;
  localparam logic [1:0] SUPERVISOR = 2'b01;
  localparam logic [1:0] MACHINE    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    SAVE_TVAL,
    SAVE_STATUS,
    REDIRECT,
    MRET_STATUS,
    MRET_REDIRECT
  } trap_state_e;

endpackage

// File: rtl/trap_cause_encoder.sv
// Combinational priority select between E-stage trap, MRET and F-stage trap,
// plus the pc/cause/tval values the sequencer captures for the winner.
module trap_cause_encoder
  import trap_sequencer_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   exception_code_f,
  input  logic [W-1:0] pc_f,
  input  logic [3:0]   exception_code_e,
  input  logic [W-1:0] pc_e,
  input  logic [W-1:0] alu_out_e,
  input  logic         mret_e,
  input  logic [1:0]   current_privilege,
  output logic         take_trap,
  output logic         take_mret,
  output logic [W-1:0] sel_pc,
  output logic [3:0]   sel_cause,
  output logic [W-1:0] sel_tval
);

  logic       e_valid;
  logic       f_valid;
  logic [3:0] sel_code;

  always_comb begin
    e_valid   = (exception_code_e != NO_E);
    f_valid   = (exception_code_f != NO_E);
    take_trap = e_valid | (~mret_e & f_valid);
    take_mret = ~e_valid & mret_e;
    sel_code  = e_valid ? exception_code_e : exception_code_f;
    sel_pc    = e_valid ? pc_e : pc_f;

    // ECALL reports the originating privilege in the cause number.
    if (sel_code == E_ECALL)
      sel_cause = ECALL_CAUSE_BASE + {2'b00, current_privilege};
    else
      sel_cause = sel_code;

    case (sel_code)
      E_LOAD_ADDR_MISALIGNED, E_LOAD_ACCESS_FAULT,
      E_STORE_ADDR_MISALIGNED, E_STORE_ACCESS_FAULT: sel_tval = alu_out_e;
      E_FETCH_ADDR_MISALIGNED:                       sel_tval = pc_f;
      default:                                       sel_tval = '0;
    endcase
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer: captures the winning event in IDLE, then walks
// the CSR writes one per cycle and finishes with a PC redirect and privilege change.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter  logic [1:0] XLEN = XLEN_64B,
  localparam int         W    = 1 << (int'(XLEN) + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_exception_code_f,
  input  logic [W-1:0] i_pc_f,
  input  logic [3:0]   i_exception_code_e,
  input  logic [W-1:0] i_pc_e,
  input  logic [W-1:0] i_alu_out_e,
  input  logic         i_mret_e,
  input  logic [1:0]   i_current_privilege,
  input  logic [W-1:0] i_mtvec,
  input  logic [W-1:0] i_mepc,
  input  logic [W-1:0] i_mstatus,
  output logic         o_flush,
  output logic         o_stall_f,
  output logic         o_csr_we,
  output logic [11:0]  o_csr_addr,
  output logic [W-1:0] o_csr_wdata,
  output logic         o_pc_redirect_valid,
  output logic [W-1:0] o_pc_redirect,
  output logic         o_priv_we,
  output logic [1:0]   o_new_privilege,
  output logic         o_busy
);

  trap_state_e state_q, state_d;

  logic         take_trap, take_mret;
  logic [W-1:0] sel_pc, sel_tval;
  logic [3:0]   sel_cause;

  logic [W-1:0] pc_q, tval_q;
  logic [3:0]   cause_q;
  logic [1:0]   prev_priv_q, mpp_q;
  logic [W-1:0] status_trap, status_mret;
  logic         accept;

  logic unused_mtvec_lsb;
  assign unused_mtvec_lsb = ^i_mtvec[1:0];

  trap_cause_encoder #(.W(W)) u_enc (
    .exception_code_f  (i_exception_code_f),
    .pc_f              (i_pc_f),
    .exception_code_e  (i_exception_code_e),
    .pc_e              (i_pc_e),
    .alu_out_e         (i_alu_out_e),
    .mret_e            (i_mret_e),
    .current_privilege (i_current_privilege),
    .take_trap         (take_trap),
    .take_mret         (take_mret),
    .sel_pc            (sel_pc),
    .sel_cause         (sel_cause),
    .sel_tval          (sel_tval)
  );

  // Only an IDLE sequencer out of reset accepts a new event.
  assign accept = i_rst_n & (state_q == IDLE) & (take_trap | take_mret);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      prev_priv_q <= '0;
      mpp_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q        <= sel_pc;
        cause_q     <= sel_cause;
        tval_q      <= sel_tval;
        prev_priv_q <= i_current_privilege;
        mpp_q       <= i_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      end
    end
  end

  always_comb begin
    status_trap = i_mstatus;
    status_trap[MSTATUS_MPIE] = i_mstatus[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]  = 1'b0;
    status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = prev_priv_q;

    status_mret = i_mstatus;
    status_mret[MSTATUS_MIE]  = i_mstatus[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE] = 1'b1;
    status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = USER;
  end

  always_comb begin
    state_d             = state_q;
    o_flush             = 1'b0;
    o_stall_f           = 1'b0;
    o_csr_we            = 1'b0;
    o_csr_addr          = '0;
    o_csr_wdata         = '0;
    o_pc_redirect_valid = 1'b0;
    o_pc_redirect       = '0;
    o_priv_we           = 1'b0;
    o_new_privilege     = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          o_flush   = 1'b1;
          o_stall_f = 1'b1;
          state_d   = take_trap ? SAVE_EPC : MRET_STATUS;
        end
      end
      SAVE_EPC: begin
        o_flush = 1'b1; o_stall_f = 1'b1;
        o_csr_we = 1'b1; o_csr_addr = CSR_MEPC; o_csr_wdata = pc_q;
        state_d = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        o_flush = 1'b1; o_stall_f = 1'b1;
        o_csr_we = 1'b1; o_csr_addr = CSR_MCAUSE; o_csr_wdata = W'(cause_q);
        state_d = SAVE_TVAL;
      end
      SAVE_TVAL: begin
        o_flush = 1'b1; o_stall_f = 1'b1;
        o_csr_we = 1'b1; o_csr_addr = CSR_MTVAL; o_csr_wdata = tval_q;
        state_d = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        o_flush = 1'b1; o_stall_f = 1'b1;
        o_csr_we = 1'b1; o_csr_addr = CSR_MSTATUS; o_csr_wdata = status_trap;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        o_flush = 1'b1; o_stall_f = 1'b1;
        o_pc_redirect_valid = 1'b1;
        o_pc_redirect       = {i_mtvec[W-1:2], 2'b00};
        o_priv_we           = 1'b1;
        o_new_privilege     = MACHINE;
        state_d = IDLE;
      end
      MRET_STATUS: begin
        o_flush = 1'b1; o_stall_f = 1'b1;
        o_csr_we = 1'b1; o_csr_addr = CSR_MSTATUS; o_csr_wdata = status_mret;
        state_d = MRET_REDIRECT;
      end
      MRET_REDIRECT: begin
        o_flush = 1'b1; o_stall_f = 1'b1;
        o_pc_redirect_valid = 1'b1;
        o_pc_redirect       = i_mepc;
        o_priv_we           = 1'b1;
        o_new_privilege     = mpp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random traffic, checked
// against a queue of expected per-cycle output records.
module tb_trap_sequencer;

  localparam logic [3:0] NONE = 4'hF;

  logic        clk, rst_n;
  logic [3:0]  code_f, code_e;
  logic [63:0] pc_f, pc_e, alu_out, mtvec, mepc, mstatus;
  logic        mret;
  logic [1:0]  priv;
  logic        flush, stall_f, csr_we, redir_v, priv_we, busy;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, redir;
  logic [1:0]  new_priv;

  int n_chk = 0, n_fail = 0, n_we = 0, n_redir = 0;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        rv;
    logic [63:0] tgt;
    logic        pwe;
    logic [1:0]  np;
  } step_t;
  step_t q[$];

  trap_sequencer #(.XLEN(2'd2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_exception_code_f(code_f), .i_pc_f(pc_f),
    .i_exception_code_e(code_e), .i_pc_e(pc_e), .i_alu_out_e(alu_out),
    .i_mret_e(mret), .i_current_privilege(priv),
    .i_mtvec(mtvec), .i_mepc(mepc), .i_mstatus(mstatus),
    .o_flush(flush), .o_stall_f(stall_f),
    .o_csr_we(csr_we), .o_csr_addr(csr_addr), .o_csr_wdata(csr_wdata),
    .o_pc_redirect_valid(redir_v), .o_pc_redirect(redir),
    .o_priv_we(priv_we), .o_new_privilege(new_priv), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mstatus rewrites: MIE bit 3, MPIE bit 7, MPP bits 12:11
  function automatic logic [63:0] trap_status(input logic [63:0] ms, input logic [1:0] pp);
    logic [63:0] r;
    r = ms; r[7] = ms[3]; r[3] = 1'b0; r[12:11] = pp;
    return r;
  endfunction

  function automatic logic [63:0] mret_status(input logic [63:0] ms);
    logic [63:0] r;
    r = ms; r[3] = ms[7]; r[7] = 1'b1; r[12:11] = 2'b00;
    return r;
  endfunction

  function automatic step_t mk(input logic we, input logic [11:0] a, input logic [63:0] d,
                               input logic rv, input logic [63:0] t, input logic [1:0] np);
    step_t s;
    s.we = we; s.addr = a; s.wdata = d; s.rv = rv; s.tgt = t; s.pwe = rv; s.np = np;
    return s;
  endfunction

  // Called at a negedge with inputs already driven; checks then advances one cycle.
  task automatic tick();
    step_t e;
    logic ef, eb;
    logic [3:0] code, cause;
    logic [63:0] tp, tv;
    #1;
    e = mk(1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 2'b00);
    ef = 1'b0; eb = 1'b0;
    if (q.size() > 0) begin
      e = q.pop_front(); ef = 1'b1; eb = 1'b1;
    end else if (rst_n && (code_e != NONE || mret || code_f != NONE)) begin
      ef = 1'b1;
      if (code_e != NONE || !mret) begin
        code  = (code_e != NONE) ? code_e : code_f;
        tp    = (code_e != NONE) ? pc_e : pc_f;
        cause = (code == 4'd8) ? 4'd8 + {2'b00, priv} : code;
        tv    = (code >= 4'd4 && code <= 4'd7) ? alu_out : (code == 4'd0) ? pc_f : 64'h0;
        q.push_back(mk(1'b1, 12'h341, tp, 1'b0, 64'h0, 2'b00));
        q.push_back(mk(1'b1, 12'h342, {60'h0, cause}, 1'b0, 64'h0, 2'b00));
        q.push_back(mk(1'b1, 12'h343, tv, 1'b0, 64'h0, 2'b00));
        q.push_back(mk(1'b1, 12'h300, trap_status(mstatus, priv), 1'b0, 64'h0, 2'b00));
        q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b1, {mtvec[63:2], 2'b00}, 2'b11));
      end else begin
        q.push_back(mk(1'b1, 12'h300, mret_status(mstatus), 1'b0, 64'h0, 2'b00));
        q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b1, mepc, mstatus[12:11]));
      end
    end
    chk("flush", {63'h0, flush}, {63'h0, ef});
    chk("stall_f", {63'h0, stall_f}, {63'h0, ef});
    chk("busy", {63'h0, busy}, {63'h0, eb});
    chk("csr_we", {63'h0, csr_we}, {63'h0, e.we});
    chk("csr_addr", {52'h0, csr_addr}, {52'h0, e.addr});
    chk("csr_wdata", csr_wdata, e.wdata);
    chk("redir_v", {63'h0, redir_v}, {63'h0, e.rv});
    chk("redir", redir, e.tgt);
    chk("priv_we", {63'h0, priv_we}, {63'h0, e.pwe});
    chk("new_priv", {62'h0, new_priv}, {62'h0, e.np});
    if (csr_we) n_we++;
    if (redir_v) n_redir++;
    if (!rst_n) q.delete();
    @(negedge clk);
  endtask

  task automatic idle_in();
    code_f = NONE; code_e = NONE; mret = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    idle_in();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; idle_in(); priv = 2'b00;
    pc_f = 64'h0; pc_e = 64'h0; alu_out = 64'h0;
    mtvec = 64'h8000_0105; mepc = 64'h0; mstatus = 64'h88;
    @(negedge clk);
    // reset: outputs stay 0 even with a code present
    code_e = 4'd4;
    tick(); tick();
    rst_n = 1'b1; idle_in(); tick();

    // 1) load misaligned from U
    priv = 2'b00; code_e = 4'd4; alu_out = 64'h1002; pc_e = 64'h80;
    tick();
    idle_in(); #1 chk("t1_mepc", csr_wdata, 64'h80); tick();
    #1 chk("t1_mcause", csr_wdata, 64'd4); tick();
    #1 chk("t1_mtval", csr_wdata, 64'h1002); tick();
    #1 chk("t1_mstatus", csr_wdata, 64'h80); tick();
    #1 chk("t1_redir", redir, 64'h8000_0104); chk("t1_priv", {62'h0, new_priv}, 64'd3); tick();
    idle_ticks(1);

    // 2) F fetch-misaligned vs E ecall from S
    priv = 2'b01; code_f = 4'd0; pc_f = 64'h102; code_e = 4'd8; pc_e = 64'h300;
    tick();
    idle_in(); #1 chk("t2_mepc", csr_wdata, 64'h300); tick();
    #1 chk("t2_mcause", csr_wdata, 64'd9); tick();
    #1 chk("t2_mtval", csr_wdata, 64'h0); tick();
    idle_ticks(3);

    // 3) MRET beats F illegal instruction
    mstatus = 64'h880; mepc = 64'h200; mret = 1'b1; code_f = 4'd2;
    tick();
    idle_in(); #1 chk("t3_mstatus", csr_wdata, 64'h88); tick();
    #1 chk("t3_redir", redir, 64'h200); chk("t3_priv", {62'h0, new_priv}, 64'd1); tick();
    idle_ticks(1);

    // 4) codes pulsed every cycle during a sequence
    mstatus = 64'h8; n_we = 0; n_redir = 0;
    for (int i = 0; i < 6; i++) begin
      code_e = 4'($urandom_range(0, 7)); pc_e = 64'h1000 + 64'(i); code_f = 4'd2;
      tick();
    end
    chk("t4_writes", 64'(n_we), 64'd4);
    chk("t4_redirects", 64'(n_redir), 64'd1);
    code_e = 4'd3;
    #1 chk("t4_new_busy", {63'h0, busy}, 64'd0); chk("t4_new_flush", {63'h0, flush}, 64'd1);
    tick();
    idle_ticks(6);

    // 5) reset mid-trap
    code_e = 4'd5; tick();
    idle_in(); tick();
    rst_n = 1'b0; tick();
    n_we = 0;
    #1 chk("t5_busy", {63'h0, busy}, 64'd0); chk("t5_we", {63'h0, csr_we}, 64'd0);
    tick();
    rst_n = 1'b1; idle_ticks(4);
    chk("t5_no_writes", 64'(n_we), 64'd0);

    // 6) ECALL from M
    priv = 2'b11; code_e = 4'd8; mstatus = 64'h8; tick();
    idle_in(); tick();
    #1 chk("t6_mcause", csr_wdata, 64'd11); tick();
    tick();
    #1 chk("t6_mstatus", csr_wdata, 64'h1880); tick();
    #1 chk("t6_redir", redir, 64'h8000_0104); tick();
    idle_ticks(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) begin
        mstatus = {$urandom, $urandom};
        mtvec   = {$urandom, $urandom};
        mepc    = {$urandom, $urandom};
      end
      code_e  = ($urandom_range(0, 9) < 6) ? NONE : 4'($urandom_range(0, 14));
      code_f  = ($urandom_range(0, 9) < 6) ? NONE : 4'($urandom_range(0, 14));
      mret    = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 2))
        0: priv = 2'b00;
        1: priv = 2'b01;
        default: priv = 2'b11;
      endcase
      pc_f    = {$urandom, $urandom};
      pc_e    = {$urandom, $urandom};
      alu_out = {$urandom, $urandom};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
